aes_cipher_iter: RTL

- Iterative AES encryption core, the forward counterpart of the team's iterative decryption block.
- Consumes a plaintext block and a pre-expanded key schedule, and performs one AES round per clock.
- Supports AES-128, AES-192 and AES-256, selected by Nk.
- Adds a start/busy/done handshake so it can sit behind a host-side command path; the core does not self-start out of reset.

---
 rtl/aes_cipher_iter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryption core: one round per clk, key length chosen by Nk at start.
// Define CIPHER_ABORT_EN to add an abort input that cancels a run in progress.
module aes_cipher_iter (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
`ifdef CIPHER_ABORT_EN
    input  logic          abort,
`endif
    input  logic [7:0]    Nk,
    input  logic [127:0]  plainText,
    input  logic [1919:0] keySchedule,
    output logic [127:0]  cipherText,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nr_of(input logic [7:0] nk);
        case (nk)
            8'd4:    return 4'd10;
            8'd6:    return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [3:0]     nr_q, nr_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   ct_q, ct_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [7:0]     sb [16];
    logic [7:0]     sr [16];
    logic [7:0]     mc [16];
    logic [127:0]   round_key;
    logic [127:0]   round_out;
    logic           last_round;

    // Single shared round datapath; MixColumns is bypassed on the final round.
    always_comb begin
        sb         = '{default: '0};
        sr         = '{default: '0};
        mc         = '{default: '0};
        round_out  = '0;
        last_round = (round_q == nr_q);
        round_key  = keySchedule[1919 - 128*int'(round_q) -: 128];
        for (int i = 0; i < 16; i++)
            sb[i] = sbox(data_q[127 - 8*i -: 8]);
        for (int i = 0; i < 16; i++)
            sr[i] = sb[(i + 4*(i % 4)) % 16];
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++)
            round_out[127 - 8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ round_key[127 - 8*i -: 8];
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        data_d  = data_q;
        ct_d    = ct_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    data_d  = plainText ^ keySchedule[1919 -: 128];
                    round_d = 4'd1;
                    nr_d    = nr_of(Nk);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (last_round) begin
                    ct_d    = round_out;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    data_d  = round_out;
                    round_d = round_q + 4'd1;
                end
`ifdef CIPHER_ABORT_EN
                // Abort overrides completion; the previous result stays visible.
                if (abort) begin
                    ct_d    = ct_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    round_d = 4'd0;
                    state_d = S_IDLE;
                end
`endif
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            nr_q    <= 4'd10;
            data_q  <= '0;
            ct_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            data_q  <= data_d;
            ct_q    <= ct_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cipherText = ct_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
